// File: rtl/muldiv_pkg.sv
// Shared encodings and defaults for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned MD_WIDTH = 32;
    localparam int unsigned OP_W     = 3;

    localparam logic [OP_W-1:0] OP_MULT  = 3'b000;
    localparam logic [OP_W-1:0] OP_MULTU = 3'b001;
    localparam logic [OP_W-1:0] OP_DIV   = 3'b010;
    localparam logic [OP_W-1:0] OP_DIVU  = 3'b011;
    localparam logic [OP_W-1:0] OP_MTHI  = 3'b100;
    localparam logic [OP_W-1:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_e;

    // Signed variants take absolute values and fix the sign at the end.
    function automatic logic op_is_signed(input logic [OP_W-1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Sign handling around the unsigned iterative core: operand magnitudes on the
// way in, conditional negation of product / quotient / remainder on the way out.
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             is_signed_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    output logic [WIDTH-1:0] abs_a_o,
    output logic [WIDTH-1:0] abs_b_o,
    input  logic             is_mul_i,
    input  logic             neg_res_i,
    input  logic             neg_rem_i,
    input  logic [WIDTH-1:0] res_hi_i,
    input  logic [WIDTH-1:0] res_lo_i,
    output logic [WIDTH-1:0] fix_hi_o,
    output logic [WIDTH-1:0] fix_lo_o
);

    localparam int unsigned PW = 2 * WIDTH;

    logic [PW-1:0] prod;
    logic [PW-1:0] prod_fix;

    // Magnitudes of the incoming operands (raw values for unsigned ops).
    always_comb begin
        abs_a_o = (is_signed_i && opa_i[WIDTH-1]) ? (~opa_i + WIDTH'(1)) : opa_i;
        abs_b_o = (is_signed_i && opb_i[WIDTH-1]) ? (~opb_i + WIDTH'(1)) : opb_i;
    end

    // Product negates as one double-width value; quotient and remainder separately.
    always_comb begin
        prod     = {res_hi_i, res_lo_i};
        prod_fix = neg_res_i ? (~prod + PW'(1)) : prod;
        if (is_mul_i) begin
            fix_hi_o = prod_fix[PW-1:WIDTH];
            fix_lo_o = prod_fix[WIDTH-1:0];
        end else begin
            fix_hi_o = neg_rem_i ? (~res_hi_i + WIDTH'(1)) : res_hi_i;
            fix_lo_o = neg_res_i ? (~res_lo_i + WIDTH'(1)) : res_lo_i;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One result bit per cycle, then a single sign-fix cycle before HI/LO update.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic [2:0]       op,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] acc_q;      // product upper half / partial remainder
    logic [WIDTH-1:0] sh_q;       // multiplier shifting out / quotient shifting in
    logic [WIDTH-1:0] mcand_q;    // multiplicand or divisor magnitude
    logic [WIDTH-1:0] opa_raw_q;  // untouched dividend, returned on divide by zero
    logic             is_mul_q;
    logic             neg_res_q;
    logic             neg_rem_q;
    logic             dbz_q;

    logic             is_signed_c;
    logic             neg_res_c;
    logic             neg_rem_c;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             q_bit;
    logic [WIDTH-1:0] mul_acc_d;
    logic [WIDTH-1:0] mul_sh_d;
    logic [WIDTH-1:0] div_acc_d;
    logic [WIDTH-1:0] div_sh_d;

    // Result-sign flags derived from the operands presented with start.
    always_comb begin
        is_signed_c = op_is_signed(op);
        neg_res_c   = is_signed_c & (opA[WIDTH-1] ^ opB[WIDTH-1]);
        neg_rem_c   = is_signed_c & opA[WIDTH-1];
    end

    muldiv_sign_fix #(
        .WIDTH (WIDTH)
    ) u_sign_fix (
        .is_signed_i (is_signed_c),
        .opa_i       (opA),
        .opb_i       (opB),
        .abs_a_o     (abs_a),
        .abs_b_o     (abs_b),
        .is_mul_i    (is_mul_q),
        .neg_res_i   (neg_res_q),
        .neg_rem_i   (neg_rem_q),
        .res_hi_i    (acc_q),
        .res_lo_i    (sh_q),
        .fix_hi_o    (fix_hi),
        .fix_lo_o    (fix_lo)
    );

    // One shift-add step and one restoring-divide step per cycle.
    always_comb begin
        add_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, mcand_q} : '0);
        mul_acc_d = add_sum[WIDTH:1];
        mul_sh_d  = {add_sum[0], sh_q[WIDTH-1:1]};

        trial     = {acc_q, sh_q[WIDTH-1]};
        diff      = trial - {1'b0, mcand_q};
        q_bit     = ~diff[WIDTH];
        div_acc_d = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        div_sh_d  = {sh_q[WIDTH-2:0], q_bit};
    end

    // Control FSM plus iterative datapath and HI/LO registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            sh_q        <= '0;
            mcand_q     <= '0;
            opa_raw_q   <= '0;
            is_mul_q    <= 1'b0;
            neg_res_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            dbz_q       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MTHI: hi <= opA;
                            OP_MTLO: lo <= opA;
                            OP_MULT, OP_MULTU: begin
                                state_q   <= ST_MUL;
                                busy      <= 1'b1;
                                cnt_q     <= CNT_W'(WIDTH - 1);
                                acc_q     <= '0;
                                sh_q      <= abs_b;
                                mcand_q   <= abs_a;
                                opa_raw_q <= opA;
                                is_mul_q  <= 1'b1;
                                neg_res_q <= neg_res_c;
                                neg_rem_q <= neg_rem_c;
                                dbz_q     <= 1'b0;
                            end
                            OP_DIV, OP_DIVU: begin
                                state_q   <= ST_DIV;
                                busy      <= 1'b1;
                                cnt_q     <= CNT_W'(WIDTH - 1);
                                acc_q     <= '0;
                                sh_q      <= abs_a;
                                mcand_q   <= abs_b;
                                opa_raw_q <= opA;
                                is_mul_q  <= 1'b0;
                                neg_res_q <= neg_res_c;
                                neg_rem_q <= neg_rem_c;
                                dbz_q     <= (opB == '0);
                            end
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    acc_q <= mul_acc_d;
                    sh_q  <= mul_sh_d;
                    if (cnt_q == '0) begin
                        state_q <= ST_FIX;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_DIV: begin
                    acc_q <= div_acc_d;
                    sh_q  <= div_sh_d;
                    if (cnt_q == '0) begin
                        state_q <= ST_FIX;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    state_q     <= ST_IDLE;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    div_by_zero <= dbz_q;
                    if (dbz_q) begin
                        hi <= opa_raw_q;
                        lo <= '1;
                    end else begin
                        hi <= fix_hi;
                        lo <= fix_lo;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a transaction-level reference model checked
// every cycle, plus literal expectations for each directed operation.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    op    = 3'b111;
    logic [W-1:0]  opA   = '0;
    logic [W-1:0]  opB   = '0;
    logic          busy;
    logic          done;
    logic          div_by_zero;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int   checks   = 0;
    int   failures = 0;
    logic chk_en   = 1'b0;

    muldiv_unit dut (
        .clk         (clk),
        .reset       (reset),
        .opA         (opA),
        .opB         (opB),
        .op          (op),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    // Architectural result of one mul/div command: {div_by_zero, hi, lo}.
    function automatic logic [2*W:0] ref_result(input logic [2:0] o,
                                                input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        longint        sa;
        longint        sb;
        longint        sq;
        longint        sr;
        logic [2*W-1:0] up;
        logic [W-1:0]   q;
        logic [W-1:0]   r;
        ref_result = '0;
        case (o)
            OP_MULT: begin
                sa = $signed(a);
                sb = $signed(b);
                sq = sa * sb;
                ref_result = {1'b0, sq[63:0]};
            end
            OP_MULTU: begin
                up = {32'b0, a} * {32'b0, b};
                ref_result = {1'b0, up};
            end
            OP_DIV, OP_DIVU: begin
                if (b == '0) begin
                    ref_result = {1'b1, a, {W{1'b1}}};
                end else if (o == OP_DIV) begin
                    sa = $signed(a);
                    sb = $signed(b);
                    sq = sa / sb;
                    sr = sa % sb;
                    ref_result = {1'b0, sr[31:0], sq[31:0]};
                end else begin
                    q = a / b;
                    r = a % b;
                    ref_result = {1'b0, r, q};
                end
            end
            default: ref_result = '0;
        endcase
    endfunction

    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic         m_dbz  = 1'b0;
    logic [W-1:0] m_hi   = '0;
    logic [W-1:0] m_lo   = '0;
    logic         p_dbz  = 1'b0;
    logic [W-1:0] p_hi   = '0;
    logic [W-1:0] p_lo   = '0;
    int           m_left = 0;

    // Reference model: accepted command completes LAT edges later.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
            if (m_busy) begin
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_dbz  <= p_dbz;
                    m_hi   <= p_hi;
                    m_lo   <= p_lo;
                end
                m_left <= m_left - 1;
            end else if (start) begin
                case (op)
                    OP_MTHI: m_hi <= opA;
                    OP_MTLO: m_lo <= opA;
                    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        {p_dbz, p_hi, p_lo} <= ref_result(op, opA, opB);
                        m_busy <= 1'b1;
                        m_left <= LAT;
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic check32(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check1 ("cyc_busy", busy, m_busy);
            check1 ("cyc_done", done, m_done);
            check1 ("cyc_dbz", div_by_zero, m_dbz);
            check32("cyc_hi", hi, m_hi);
            check32("cyc_lo", lo, m_lo);
        end
    end

    // Present a command for exactly one rising edge, then scramble operands.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        op    = o;
        opA   = a;
        opB   = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op    = 3'($urandom_range(0, 7));
        opA   = $urandom;
        opB   = $urandom;
    endtask

    // Wait (bounded) for done, counting cycles with busy high.
    task automatic wait_done(output int busy_cnt, output logic found);
        busy_cnt = 0;
        found    = 1'b0;
        for (int i = 0; i < 3 * LAT && !found; i++) begin
            if (busy) busy_cnt++;
            if (done) found = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic run(input string nm, input logic [2:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] eh,
                       input logic [W-1:0] el, input logic ed);
        int   bc;
        logic found;
        issue(o, a, b);
        wait_done(bc, found);
        check1 ({nm, "_done_seen"}, found, 1'b1);
        check32({nm, "_busy_cycles"}, W'(bc), W'(LAT));
        check32({nm, "_hi"}, hi, eh);
        check32({nm, "_lo"}, lo, el);
        check1 ({nm, "_dbz"}, div_by_zero, ed);
    endtask

    initial begin
        int   bc;
        logic found;

        #1 reset = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        check32("rst_hi", hi, 32'h0);
        check32("rst_lo", lo, 32'h0);
        check1 ("rst_busy", busy, 1'b0);
        check1 ("rst_done", done, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        run("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        @(negedge clk);
        run("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run("mult_min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);
        @(negedge clk);
        run("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run("div_negb", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
        run("divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
        @(negedge clk);
        run("divu_zero", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
        run("divu_after0", OP_DIVU, 32'd6, 32'd3, 32'd0, 32'd2, 1'b0);
        run("div_zero_s", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
        @(negedge clk);

        // MTHI in idle: immediate, no busy.
        issue(OP_MTHI, 32'h0000_1234, 32'h0);
        check32("mthi_hi", hi, 32'h0000_1234);
        check1 ("mthi_busy", busy, 1'b0);
        check1 ("mthi_done", done, 1'b0);

        // Invalid op leaves everything alone.
        issue(3'b110, 32'hAAAA_AAAA, 32'hBBBB_BBBB);
        check32("nop_hi", hi, 32'h0000_1234);
        check32("nop_lo", lo, 32'hFFFF_FFFF);
        check1 ("nop_busy", busy, 1'b0);

        // MTLO while a MULT runs is ignored.
        issue(OP_MULT, 32'd5, 32'hFFFF_FFFA);
        repeat (3) @(negedge clk);
        op    = OP_MTLO;
        opA   = 32'hDEAD_BEEF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(bc, found);
        check1 ("mtlo_busy_done_seen", found, 1'b1);
        check32("mtlo_busy_hi", hi, 32'hFFFF_FFFF);
        check32("mtlo_busy_lo", lo, 32'hFFFF_FFE2);
        @(negedge clk);

        // Reset mid-divide aborts at once.
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check32("abort_hi", hi, 32'h0);
        check32("abort_lo", lo, 32'h0);
        check1 ("abort_busy", busy, 1'b0);
        check1 ("abort_done", done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run("multu_post", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
